// File: rtl/stage2_decode_pkg.sv
// Shared constants, control-word type and decode helpers for the SCU instruction-decode stage.
// The optional write-back bypass is enabled with the WB_BYPASS_EN macro (see regfile_64x32).
package stage2_decode_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_REG_AW = 6;

    localparam logic [3:0] OP_NOP  = 4'b0000;
    localparam logic [3:0] OP_ST   = 4'b0011;
    localparam logic [3:0] OP_ADD  = 4'b0100;
    localparam logic [3:0] OP_INC  = 4'b0101;
    localparam logic [3:0] OP_NEG  = 4'b0110;
    localparam logic [3:0] OP_SUB  = 4'b0111;
    localparam logic [3:0] OP_J    = 4'b1000;
    localparam logic [3:0] OP_BRZ  = 4'b1001;
    localparam logic [3:0] OP_JM   = 4'b1010;
    localparam logic [3:0] OP_BRN  = 4'b1011;
    localparam logic [3:0] OP_LD   = 4'b1110;
    localparam logic [3:0] OP_SVPC = 4'b1111;

    localparam logic [2:0] ALU_ADD    = 3'b000;
    localparam logic [2:0] ALU_SUB    = 3'b001;
    localparam logic [2:0] ALU_NEG    = 3'b010;
    localparam logic [2:0] ALU_PASS_A = 3'b011;

    localparam int OP_MSB  = 31;
    localparam int OP_LSB  = 28;
    localparam int RD_MSB  = 27;
    localparam int RD_LSB  = 22;
    localparam int RS_MSB  = 21;
    localparam int RS_LSB  = 16;
    localparam int RT_MSB  = 15;
    localparam int RT_LSB  = 10;
    localparam int IMM_MSB = 15;

    typedef struct packed {
        logic       memWrite;
        logic       memRead;
        logic       ALUSRC;
        logic       regWrite;
        logic       WAI;
        logic [2:0] ALUOP;
        logic       jump;
        logic       brz;
        logic       brn;
        logic       jm;
    } ctrl_t;

    // Unlisted opcodes fall through to the all-zero NOP control word.
    function automatic ctrl_t decode_op(input logic [3:0] op);
        ctrl_t c;
        c = '0;
        case (op)
            OP_SVPC: begin c.regWrite = 1'b1; c.WAI = 1'b1; c.ALUSRC = 1'b1; c.ALUOP = ALU_ADD; end
            OP_LD:   begin c.regWrite = 1'b1; c.memRead = 1'b1; c.ALUOP = ALU_PASS_A; end
            OP_ST:   begin c.memWrite = 1'b1; c.ALUOP = ALU_PASS_A; end
            OP_ADD:  begin c.regWrite = 1'b1; c.ALUOP = ALU_ADD; end
            OP_INC:  begin c.regWrite = 1'b1; c.ALUSRC = 1'b1; c.ALUOP = ALU_ADD; end
            OP_NEG:  begin c.regWrite = 1'b1; c.ALUOP = ALU_NEG; end
            OP_SUB:  begin c.regWrite = 1'b1; c.ALUOP = ALU_SUB; end
            OP_J:    c.jump = 1'b1;
            OP_BRZ:  c.brz = 1'b1;
            OP_JM:   begin c.jm = 1'b1; c.memRead = 1'b1; end
            OP_BRN:  c.brn = 1'b1;
            default: c = '0;
        endcase
        return c;
    endfunction

    function automatic logic [31:0] sign_extend16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

endpackage

// File: rtl/stage2_decode_regfile.sv
// 64 x 32 register file: two combinational read ports, one synchronous write port, async clear.
// Defining WB_BYPASS_EN forwards same-cycle write-back data onto a matching read port.
module regfile_64x32
    import stage2_decode_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int REG_AW = DEF_REG_AW
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [REG_AW-1:0] rs_addr,
    input  logic [REG_AW-1:0] rt_addr,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    input  logic              wr_en,
    input  logic [REG_AW-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data
);

    localparam int DEPTH = 2 ** REG_AW;

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

`ifdef WB_BYPASS_EN
    // Forwarding lets a reader in the write cycle see the value being written.
    assign rs_data = (wr_en && (wr_addr == rs_addr)) ? wr_data : mem[rs_addr];
    assign rt_data = (wr_en && (wr_addr == rt_addr)) ? wr_data : mem[rt_addr];
`else
    assign rs_data = mem[rs_addr];
    assign rt_data = mem[rt_addr];
`endif

endmodule

// File: rtl/stage2_decode.sv
// SCU instruction-decode stage: decodes the control word, reads the register file and
// registers everything stage 3 needs into the ID/EX buffer. Optional macro: WB_BYPASS_EN.
module stage2_decode
    import stage2_decode_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int REG_AW = DEF_REG_AW
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [31:0]       instr,
    input  logic [31:0]       PC_in,
    input  logic              stall,
    input  logic              flush,
    input  logic              wb_regWrite,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic [DATA_W-1:0] wb_data,
    output logic              memWrite,
    output logic              memRead,
    output logic              ALUSRC,
    output logic              regWrite,
    output logic              WAI,
    output logic [2:0]        ALUOP,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    output logic [DATA_W-1:0] imm,
    output logic [31:0]       PC,
    output logic [REG_AW-1:0] rd,
    output logic              jump,
    output logic              brz,
    output logic              brn,
    output logic              jm
);

    logic [3:0]        op_field;
    logic [REG_AW-1:0] rd_field;
    logic [REG_AW-1:0] rs_field;
    logic [REG_AW-1:0] rt_field;
    logic [DATA_W-1:0] rs_val;
    logic [DATA_W-1:0] rt_val;
    logic [DATA_W-1:0] imm_ext;
    ctrl_t             ctrl_d;
    ctrl_t             ctrl_q;

    assign op_field = instr[OP_MSB:OP_LSB];
    assign rd_field = instr[RD_MSB:RD_LSB];
    assign rs_field = instr[RS_MSB:RS_LSB];
    assign rt_field = instr[RT_MSB:RT_LSB];
    assign imm_ext  = DATA_W'(sign_extend16(instr[IMM_MSB:0]));

    regfile_64x32 #(
        .DATA_W (DATA_W),
        .REG_AW (REG_AW)
    ) u_regfile (
        .clock   (clock),
        .reset_n (reset_n),
        .rs_addr (rs_field),
        .rt_addr (rt_field),
        .rs_data (rs_val),
        .rt_data (rt_val),
        .wr_en   (wb_regWrite),
        .wr_addr (wb_rd),
        .wr_data (wb_data)
    );

    always_comb begin
        ctrl_d = decode_op(op_field);
    end

    // Flush outranks stall so a squashed instruction can never be held in the buffer.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_q <= '0;
            rd1    <= '0;
            rd2    <= '0;
            imm    <= '0;
            PC     <= '0;
            rd     <= '0;
        end else if (flush) begin
            ctrl_q <= '0;
            rd1    <= '0;
            rd2    <= '0;
            imm    <= '0;
            PC     <= '0;
            rd     <= '0;
        end else if (!stall) begin
            ctrl_q <= ctrl_d;
            rd1    <= rs_val;
            rd2    <= rt_val;
            imm    <= imm_ext;
            PC     <= PC_in;
            rd     <= rd_field;
        end
    end

    assign memWrite = ctrl_q.memWrite;
    assign memRead  = ctrl_q.memRead;
    assign ALUSRC   = ctrl_q.ALUSRC;
    assign regWrite = ctrl_q.regWrite;
    assign WAI      = ctrl_q.WAI;
    assign ALUOP    = ctrl_q.ALUOP;
    assign jump     = ctrl_q.jump;
    assign brz      = ctrl_q.brz;
    assign brn      = ctrl_q.brn;
    assign jm       = ctrl_q.jm;

endmodule

// File: tb/tb_stage2_decode.sv
// Directed, scoreboard-based bench for stage2_decode; follows WB_BYPASS_EN if it is defined.
module tb_stage2_decode;

    typedef struct packed {
        logic        memWrite;
        logic        memRead;
        logic        ALUSRC;
        logic        regWrite;
        logic        WAI;
        logic [2:0]  ALUOP;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [31:0] PC;
        logic [5:0]  rd;
        logic        jump;
        logic        brz;
        logic        brn;
        logic        jm;
    } exp_t;

    logic        clock = 1'b0;
    logic        clockRun = 1'b1;
    logic        reset_n;
    logic [31:0] instr;
    logic [31:0] PC_in;
    logic        stall;
    logic        flush;
    logic        wb_regWrite;
    logic [5:0]  wb_rd;
    logic [31:0] wb_data;
    logic        memWrite, memRead, ALUSRC, regWrite, WAI;
    logic [2:0]  ALUOP;
    logic [31:0] rd1, rd2, imm, PC;
    logic [5:0]  rd;
    logic        jump, brz, brn, jm;

    int          assertCount = 0;
    int          failCount = 0;
    exp_t        expQueue[$];
    exp_t        lastExp;
    logic [31:0] shadowRf [64];

    stage2_decode dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .instr       (instr),
        .PC_in       (PC_in),
        .stall       (stall),
        .flush       (flush),
        .wb_regWrite (wb_regWrite),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
        .memWrite    (memWrite),
        .memRead     (memRead),
        .ALUSRC      (ALUSRC),
        .regWrite    (regWrite),
        .WAI         (WAI),
        .ALUOP       (ALUOP),
        .rd1         (rd1),
        .rd2         (rd2),
        .imm         (imm),
        .PC          (PC),
        .rd          (rd),
        .jump        (jump),
        .brz         (brz),
        .brn         (brn),
        .jm          (jm)
    );

    always #5 if (clockRun) clock = ~clock;

    function automatic logic [31:0] mkInstr(input logic [3:0] op, input logic [5:0] d,
                                            input logic [5:0] s, input logic [15:0] low);
        return {op, d, s, low};
    endfunction

    function automatic logic [15:0] rtLow(input logic [5:0] t);
        return {t, 10'd0};
    endfunction

    // Reference decode written straight from the opcode table.
    function automatic exp_t modelDecode(input logic [31:0] ins, input logic [31:0] pc,
                                         input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        e = '0;
        e.rd1 = a;
        e.rd2 = b;
        e.imm = {{16{ins[15]}}, ins[15:0]};
        e.PC  = pc;
        e.rd  = ins[27:22];
        case (ins[31:28])
            4'hF: begin e.regWrite = 1; e.WAI = 1; e.ALUSRC = 1; e.ALUOP = 3'd0; end
            4'hE: begin e.regWrite = 1; e.memRead = 1; e.ALUOP = 3'd3; end
            4'h3: begin e.memWrite = 1; e.ALUOP = 3'd3; end
            4'h4: begin e.regWrite = 1; e.ALUOP = 3'd0; end
            4'h5: begin e.regWrite = 1; e.ALUSRC = 1; e.ALUOP = 3'd0; end
            4'h6: begin e.regWrite = 1; e.ALUOP = 3'd2; end
            4'h7: begin e.regWrite = 1; e.ALUOP = 3'd1; end
            4'h8: e.jump = 1;
            4'h9: e.brz = 1;
            4'hA: begin e.jm = 1; e.memRead = 1; end
            4'hB: e.brn = 1;
            default: ;
        endcase
        return e;
    endfunction

    function automatic exp_t observed();
        exp_t o;
        o = '{memWrite, memRead, ALUSRC, regWrite, WAI, ALUOP, rd1, rd2, imm, PC, rd,
              jump, brz, brn, jm};
        return o;
    endfunction

    task automatic checkField(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assertCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput(input string tag);
        exp_t e;
        exp_t o;
        o = observed();
        assertCount++;
        if (expQueue.size() == 0) begin
            failCount++;
            $error("[TB] FAIL %s observed=%h expected=<empty scoreboard>", tag, o);
        end else begin
            e = expQueue.pop_front();
            assert (o === e) else begin
                failCount++;
                $error("[TB] FAIL %s observed=%h expected=%h", tag, o, e);
            end
        end
    endtask

    // Drives one cycle of inputs at the falling edge, predicts the ID/EX contents,
    // then checks them just after the rising edge.
    task automatic applyStimulus(input string tag, input logic [31:0] ins, input logic [31:0] pc,
                                 input logic st, input logic fl, input logic wbEn,
                                 input logic [5:0] wbRd, input logic [31:0] wbVal);
        logic [31:0] a;
        logic [31:0] b;
        exp_t        e;
        @(negedge clock);
        instr = ins; PC_in = pc; stall = st; flush = fl;
        wb_regWrite = wbEn; wb_rd = wbRd; wb_data = wbVal;
        a = shadowRf[ins[21:16]];
        b = shadowRf[ins[15:10]];
`ifdef WB_BYPASS_EN
        if (wbEn && wbRd == ins[21:16]) a = wbVal;
        if (wbEn && wbRd == ins[15:10]) b = wbVal;
`endif
        if (fl)       e = '0;
        else if (st)  e = lastExp;
        else          e = modelDecode(ins, pc, a, b);
        if (wbEn) shadowRf[wbRd] = wbVal;
        lastExp = e;
        expQueue.push_back(e);
        @(posedge clock);
        #1;
        checkOutput(tag);
    endtask

    task automatic wbWrite(input logic [5:0] r, input logic [31:0] v);
        applyStimulus("wb_write", 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, r, v);
    endtask

    initial begin
        logic [3:0] opList [8];
        opList = '{4'h3, 4'h6, 4'h8, 4'h9, 4'hA, 4'hB, 4'h1, 4'hC};
        for (int i = 0; i < 64; i++) shadowRf[i] = '0;
        lastExp = '0;
        reset_n = 1'b0; instr = '0; PC_in = '0; stall = 0; flush = 0;
        wb_regWrite = 0; wb_rd = '0; wb_data = '0;
        #12;
        checkField("power_on_reset", observed() == '0, 1'b1);
        @(negedge clock);
        reset_n = 1'b1;

        wbWrite(6'd5, 32'h0000_0123);
        applyStimulus("pre_reset_add", mkInstr(4'h4, 6'd1, 6'd5, rtLow(6'd5)), 32'h10, 0, 0, 0, 0, 0);

        // Mid-stream asynchronous reset with the clock stopped
        @(negedge clock);
        clockRun = 1'b0;
        reset_n = 1'b0;
        #2;
        checkField("async_reset_clears", observed() == '0, 1'b1);
        for (int i = 0; i < 64; i++) shadowRf[i] = '0;
        lastExp = '0;
        #3;
        reset_n = 1'b1;
        clockRun = 1'b1;

        applyStimulus("rf_cleared", mkInstr(4'h4, 6'd1, 6'd5, rtLow(6'd6)), 32'h14, 0, 0, 0, 0, 0);
        checkField("rf5_zero_after_reset", rd1, 32'h0);
        wbWrite(6'd5, 32'h0000_0007);
        wbWrite(6'd6, 32'h0000_0003);

        applyStimulus("add", mkInstr(4'h4, 6'd7, 6'd5, rtLow(6'd6)), 32'h20, 0, 0, 0, 0, 0);
        checkField("add_aluop", 32'(ALUOP), 32'h0);
        checkField("add_regwrite", 32'(regWrite), 32'h1);
        checkField("add_rd1", rd1, 32'h7);
        checkField("add_rd2", rd2, 32'h3);
        checkField("add_rd", 32'(rd), 32'h7);
        checkField("add_alusrc", 32'(ALUSRC), 32'h0);

        applyStimulus("inc", mkInstr(4'h5, 6'd8, 6'd5, 16'hFFFE), 32'h24, 0, 0, 0, 0, 0);
        checkField("inc_imm", imm, 32'hFFFF_FFFE);
        checkField("inc_alusrc", 32'(ALUSRC), 32'h1);

        applyStimulus("ld", mkInstr(4'hE, 6'd2, 6'd6, 16'h0004), 32'h28, 0, 0, 0, 0, 0);
        checkField("ld_memread", 32'(memRead), 32'h1);
        checkField("ld_aluop", 32'(ALUOP), 32'h3);
        applyStimulus("svpc", mkInstr(4'hF, 6'd3, 6'd0, 16'h0010), 32'h40, 0, 0, 0, 0, 0);
        checkField("svpc_wai", 32'(WAI), 32'h1);
        checkField("svpc_pc", PC, 32'h40);
        checkField("svpc_regwrite", 32'(regWrite), 32'h1);

        for (int i = 0; i < 8; i++) begin
            applyStimulus("opcode_table", mkInstr(opList[i], 6'(i), 6'd5, {6'd6, 10'h155}),
                          32'h100 + 32'(i), 0, 0, 0, 0, 0);
        end

        // Stall holds SUB while a write-back lands, then flush wins over stall
        applyStimulus("sub", mkInstr(4'h7, 6'd4, 6'd5, rtLow(6'd6)), 32'h80, 0, 0, 0, 0, 0);
        applyStimulus("stall1", mkInstr(4'h6, 6'd9, 6'd6, rtLow(6'd5)), 32'h84, 1, 0, 1, 6'd12, 32'h55);
        applyStimulus("stall2", mkInstr(4'h6, 6'd9, 6'd6, rtLow(6'd5)), 32'h88, 1, 0, 0, 0, 0);
        checkField("stall_hold_aluop", 32'(ALUOP), 32'h1);
        checkField("stall_hold_pc", PC, 32'h80);
        applyStimulus("flush_stall", mkInstr(4'h4, 6'd9, 6'd6, rtLow(6'd5)), 32'h8C, 1, 1, 0, 0, 0);
        checkField("flush_zero", observed() == '0, 1'b1);
        applyStimulus("wb_during_stall", mkInstr(4'h4, 6'd1, 6'd12, rtLow(6'd0)), 32'h90, 0, 0, 0, 0, 0);
        checkField("rf12_written", rd1, 32'h55);

        // Same-cycle write and read of RF[9]
        wbWrite(6'd9, 32'h11);
        applyStimulus("same_cycle_rw", mkInstr(4'h4, 6'd1, 6'd9, rtLow(6'd0)), 32'h94, 0, 0, 1, 6'd9, 32'hAA);
`ifdef WB_BYPASS_EN
        checkField("bypass_rd1", rd1, 32'hAA);
`else
        checkField("no_bypass_rd1", rd1, 32'h11);
`endif
        applyStimulus("after_write", mkInstr(4'h4, 6'd1, 6'd9, rtLow(6'd9)), 32'h98, 0, 0, 0, 0, 0);
        checkField("rf9_new_value", rd1, 32'hAA);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
